// File: rtl/prog_loader.sv
// prog_loader: receives framed bytes from a UART receiver and writes 32-bit words
// into the write port of the instruction memory. busy holds the CPU in reset while loading.
module prog_loader #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned TIMEOUT = 50000,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       wr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR_H = 3'd1;
    localparam logic [2:0] S_ADDR_L = 3'd2;
    localparam logic [2:0] S_LEN_H  = 3'd3;
    localparam logic [2:0] S_LEN_L  = 3'd4;
    localparam logic [2:0] S_DATA   = 3'd5;
    localparam logic [2:0] S_CSUM   = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        addr_h_q, addr_h_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic [15:0]       len_next;
    logic [31:0]       asm_next;

    // Frame parser, word assembly, checksum and inter-byte timeout
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        addr_h_d   = addr_h_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        wdata_d    = wdata_q;
        wr_count_d = wr_count_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        len_next   = {len_q[15:8], rx_data};
        asm_next   = {asm_q[23:0], rx_data};
        // Address steps on the cycle after each write pulse
        waddr_d    = we_q ? waddr_q + 1'b1 : waddr_q;
        // Timeout counter only runs inside a frame and restarts on every byte
        tmo_d      = (state_q == S_IDLE || rx_valid) ? 32'd0 : tmo_q + 32'd1;

        if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == SYNC) begin
                        state_d    = S_ADDR_H;
                        sum_d      = 8'd0;
                        wr_count_d = 16'd0;
                        byte_cnt_d = 2'd0;
                    end
                end
                S_ADDR_H: begin
                    addr_h_d = rx_data;
                    sum_d    = sum_q + rx_data;
                    state_d  = S_ADDR_L;
                end
                S_ADDR_L: begin
                    // Upper address bits beyond the memory depth are dropped
                    waddr_d = ADDR_W'({addr_h_q, rx_data});
                    sum_d   = sum_q + rx_data;
                    state_d = S_LEN_H;
                end
                S_LEN_H: begin
                    len_d[15:8] = rx_data;
                    sum_d       = sum_q + rx_data;
                    state_d     = S_LEN_L;
                end
                S_LEN_L: begin
                    len_d   = len_next;
                    sum_d   = sum_q + rx_data;
                    state_d = (len_next == 16'd0) ? S_CSUM : S_DATA;
                end
                S_DATA: begin
                    asm_d      = asm_next;
                    sum_d      = sum_q + rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        wdata_d    = asm_next;
                        wr_count_d = wr_count_q + 16'd1;
                        if (wr_count_q + 16'd1 == len_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    done_d  = (rx_data == sum_q);
                    err_d   = (rx_data != sum_q);
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && tmo_q == TIMEOUT - 32'd1) begin
            // A byte on the same cycle takes priority, so this is the else branch
            err_d   = 1'b1;
            state_d = S_IDLE;
        end
    end

    // State registers with synchronous reset; reset abandons any partial frame silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sum_q      <= 8'd0;
            addr_h_q   <= 8'd0;
            len_q      <= 16'd0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 32'd0;
            tmo_q      <= 32'd0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= 32'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            addr_h_q   <= addr_h_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            tmo_q      <= tmo_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scoreboard of expected memory writes plus per-scenario tasks.
module tb_prog_loader;

    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned TIMEOUT = 64;
    localparam logic [7:0]  SYNC    = 8'hA5;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       wr_count;

    int n_checks = 0;
    int n_pass   = 0;
    int done_seen = 0;
    int err_seen  = 0;

    logic [ADDR_W+31:0] exp_q[$];
    logic [31:0]        pay[8];

    prog_loader #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT),
        .SYNC   (SYNC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write pulse must match the oldest expected {addr, data}
    always @(negedge clk) begin
        logic [ADDR_W+31:0] e;
        if (we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_unexpected: got addr=%h data=%h, required no write", waddr, wdata);
            end else begin
                e = exp_q.pop_front();
                if ({waddr, wdata} !== e)
                    $display("FAIL write_match: got addr=%h data=%h, required addr=%h data=%h",
                             waddr, wdata, e[ADDR_W+31:32], e[31:0]);
                else n_pass++;
            end
        end
        if (done === 1'b1) done_seen++;
        if (err === 1'b1) err_seen++;
    end

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends a full frame from pay[], queues expected writes and checks the ending
    task automatic run_frame(input logic [15:0] addr, input logic [15:0] len, input bit bad);
        logic [7:0]        s;
        logic [ADDR_W-1:0] a;
        logic [7:0]        hdr[4];
        logic [7:0]        b;
        int                e0;
        int                d0;
        d0 = done_seen;
        e0 = err_seen;
        s  = 8'd0;
        a  = addr[ADDR_W-1:0];
        hdr[0] = addr[15:8];
        hdr[1] = addr[7:0];
        hdr[2] = len[15:8];
        hdr[3] = len[7:0];
        send_byte(SYNC);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_rise: got %b, required 1", busy);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            s = s + hdr[i];
            send_byte(hdr[i]);
        end
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back({a, pay[i]});
            a = a + 1'b1;
            for (int k = 3; k >= 0; k--) begin
                b = pay[i][8*k +: 8];
                s = s + b;
                send_byte(b);
            end
        end
        send_byte(bad ? s - 8'd1 : s);
        n_checks++;
        if (done !== !bad || err !== bad || busy !== 1'b0)
            $display("FAIL frame_end: got done=%b err=%b busy=%b, required done=%b err=%b busy=0",
                     done, err, busy, !bad, bad);
        else n_pass++;
        n_checks++;
        if (wr_count !== len) $display("FAIL wr_count: got %0d, required %0d", wr_count, len);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL writes_missing: got %0d pending, required 0", exp_q.size());
        else n_pass++;
        idle_cycles(1);
        n_checks++;
        if (waddr !== a) $display("FAIL waddr_after: got %h, required %h", waddr, a);
        else n_pass++;
        n_checks++;
        if (done !== 1'b0 || err !== 1'b0 || done_seen - d0 != int'(!bad) || err_seen - e0 != int'(bad))
            $display("FAIL pulse_width: got done=%b err=%b dpulses=%0d epulses=%0d, required one-cycle",
                     done, err, done_seen - d0, err_seen - e0);
        else n_pass++;
    endtask

    task automatic test_reset;
        n_checks++;
        if (we !== 1'b0 || waddr !== '0 || wdata !== 32'd0 || busy !== 1'b0 || done !== 1'b0 ||
            err !== 1'b0 || wr_count !== 16'd0)
            $display("FAIL reset_state: got we=%b waddr=%h wdata=%h busy=%b done=%b err=%b cnt=%0d, required all 0",
                     we, waddr, wdata, busy, done, err, wr_count);
        else n_pass++;
    endtask

    task automatic test_single_word;
        pay[0] = 32'hDEADBEEF;
        run_frame(16'h0010, 16'd1, 1'b0);
    endtask

    task automatic test_bad_csum;
        pay[0] = 32'hDEADBEEF;
        run_frame(16'h0010, 16'd1, 1'b1);
    endtask

    task automatic test_zero_len;
        run_frame(16'h0005, 16'd0, 1'b0);
    endtask

    task automatic test_wrap;
        pay[0] = 32'h11111111;
        pay[1] = 32'h22222222;
        run_frame(16'h01FF, 16'd2, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 5; i++) pay[i] = $urandom;
        // Upper address bits must be ignored
        run_frame(16'hFE7C, 16'd5, 1'b0);
    endtask

    task automatic test_timeout;
        int i;
        int e0;
        e0 = err_seen;
        send_byte(8'h3C);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL noise_ignored: got busy=%b, required 0", busy);
        else n_pass++;
        send_byte(SYNC);
        send_byte(8'h00);
        send_byte(8'h00);
        for (i = 1; i <= int'(TIMEOUT) + 10; i++) begin
            @(posedge clk);
            #1;
            if (err === 1'b1) break;
        end
        n_checks++;
        if (i != int'(TIMEOUT) || busy !== 1'b0)
            $display("FAIL timeout: got err after %0d cycles busy=%b, required %0d cycles busy=0",
                     i, busy, TIMEOUT);
        else n_pass++;
        idle_cycles(1);
        n_checks++;
        if (err_seen - e0 != 1) $display("FAIL timeout_pulse: got %0d pulses, required 1", err_seen - e0);
        else n_pass++;
        pay[0] = 32'h0BADF00D;
        run_frame(16'h0040, 16'd1, 1'b0);
    endtask

    task automatic test_timeout_tie;
        int e0;
        e0 = err_seen;
        send_byte(SYNC);
        idle_cycles(int'(TIMEOUT) - 1);
        send_byte(8'h00);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1 || err_seen != e0)
            $display("FAIL timeout_tie: got err=%b busy=%b, required err=0 busy=1", err, busy);
        else n_pass++;
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
    endtask

    task automatic test_mid_reset;
        int d0;
        int e0;
        d0 = done_seen;
        e0 = err_seen;
        send_byte(SYNC);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        idle_cycles(2);
        test_reset();
        n_checks++;
        if (done_seen != d0 || err_seen != e0)
            $display("FAIL reset_no_pulse: got done=%0d err=%0d pulses, required 0",
                     done_seen - d0, err_seen - e0);
        else n_pass++;
        pay[0] = 32'hCAFEF00D;
        pay[1] = 32'h12345678;
        run_frame(16'h0020, 16'd2, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle_cycles(3);
        rst = 1'b0;
        test_reset();
        test_single_word();
        test_bad_csum();
        test_zero_len();
        test_wrap();
        test_back_to_back();
        test_timeout();
        test_timeout_tie();
        test_mid_reset();
        idle_cycles(3);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL final_queue: got %0d pending, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
